// File: rtl/rename_pkg.sv
// Shared widths, tag encoding and types for the register rename file.
package rename_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int ROB_IDX_W = 4;
  localparam int TAG_W     = ROB_IDX_W + 1;
  localparam int OP_W      = 8;
  localparam int ROB_DEPTH = 1 << ROB_IDX_W;

  // MSB set marks "no producer"; valid tags always have the MSB clear.
  localparam logic [TAG_W-1:0] TAG_INVALID = {1'b1, {ROB_IDX_W{1'b0}}};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rename_entry_t;

  typedef enum logic {ST_IDLE, ST_GRANT} alloc_state_e;

  function automatic logic [TAG_W-1:0] rob_idx_to_tag(input logic [ROB_IDX_W-1:0] idx);
    return {1'b0, idx};
  endfunction
endpackage

// File: rtl/reg_rename_file_if.sv
// Decoder / ROB facing signals of the rename file, bundled for port lists.
interface reg_rename_file_if import rename_pkg::*;;
  logic                   alloc_req;
  logic [REG_W-1:0]       alloc_rd;
  logic [OP_W-1:0]        alloc_op;
  logic                   alloc_ack;
  logic [TAG_W-1:0]       alloc_tag;
  logic                   rob_full;
  logic [ROB_IDX_W-1:0]   rob_avail_tag;
  logic                   rob_alloc_valid;
  logic [REG_W-1:0]       rob_alloc_rd;
  logic [OP_W-1:0]        rob_alloc_op;
  logic [TAG_W-1:0]       wb_tag;
  logic [REG_W-1:0]       wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic                   flush;
  logic [REG_W-1:0]       rs1_addr;
  logic [REG_W-1:0]       rs2_addr;
  logic [DATA_W-1:0]      rs1_data;
  logic [DATA_W-1:0]      rs2_data;
  logic [TAG_W-1:0]       rs1_tag;
  logic [TAG_W-1:0]       rs2_tag;
  logic [ROB_IDX_W:0]     inflight;

  modport slave (
    input  alloc_req, alloc_rd, alloc_op, rob_full, rob_avail_tag,
           wb_tag, wb_rd, wb_data, flush, rs1_addr, rs2_addr,
    output alloc_ack, alloc_tag, rob_alloc_valid, rob_alloc_rd, rob_alloc_op,
           rs1_data, rs2_data, rs1_tag, rs2_tag, inflight
  );

  modport master (
    output alloc_req, alloc_rd, alloc_op, rob_full, rob_avail_tag,
           wb_tag, wb_rd, wb_data, flush, rs1_addr, rs2_addr,
    input  alloc_ack, alloc_tag, rob_alloc_valid, rob_alloc_rd, rob_alloc_op,
           rs1_data, rs2_data, rs1_tag, rs2_tag, inflight
  );
endinterface

// File: rtl/rename_tag_table.sv
// Per-register youngest-producer tag; x0 never holds a tag.
module rename_tag_table import rename_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [REG_W-1:0] alloc_rd,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag
);
  logic [TAG_W-1:0] tag_q [REG_NUM];
  logic [TAG_W-1:0] tag_d [REG_NUM];

  // A new rename beats a retiring older producer; a retire only clears its own tag.
  always_comb begin
    tag_d = tag_q;
    for (int i = 1; i < REG_NUM; i++) begin
      if (flush)
        tag_d[i] = TAG_INVALID;
      else if (alloc_en && alloc_rd == REG_W'(i))
        tag_d[i] = alloc_tag;
      else if (wb_en && wb_rd == REG_W'(i) && tag_q[i] == wb_tag)
        tag_d[i] = TAG_INVALID;
    end
    tag_d[0] = TAG_INVALID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) tag_q[i] <= TAG_INVALID;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign rs1_tag = tag_q[rs1_addr];
  assign rs2_tag = tag_q[rs2_addr];
endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags, ROB tag allocation and retire bypass.
module reg_rename_file import rename_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  reg_rename_file_if.slave  bus
);
  localparam logic [ROB_IDX_W:0] INFLIGHT_MAX = (ROB_IDX_W+1)'(ROB_DEPTH);

  alloc_state_e        state_q, state_d;
  logic [TAG_W-1:0]    alloc_tag_q, alloc_tag_d;
  logic [REG_W-1:0]    rob_alloc_rd_q, rob_alloc_rd_d;
  logic [OP_W-1:0]     rob_alloc_op_q, rob_alloc_op_d;
  logic [ROB_IDX_W:0]  inflight_q, inflight_d;
  logic [DATA_W-1:0]   data_q [REG_NUM];
  logic [DATA_W-1:0]   data_d [REG_NUM];
  logic                accept, wb_valid, retire;
  logic [TAG_W-1:0]    rs1_tag_raw, rs2_tag_raw;
  rename_entry_t       rs1_ent, rs2_ent;

  assign wb_valid = (bus.wb_tag != TAG_INVALID);
  assign retire   = wb_valid && (inflight_q != '0);
  assign accept   = bus.alloc_req && !bus.rob_full && !bus.flush && (inflight_q < INFLIGHT_MAX);

  function automatic rename_entry_t read_port(
    input logic [REG_W-1:0]  addr,
    input logic [DATA_W-1:0] reg_data,
    input logic [TAG_W-1:0]  reg_tag,
    input logic              wb_v,
    input logic [REG_W-1:0]  wrd,
    input logic [TAG_W-1:0]  wtag,
    input logic [DATA_W-1:0] wdata
  );
    rename_entry_t e;
    if (addr == '0)
      e = '{data: '0, tag: TAG_INVALID};
    else if (wb_v && wrd == addr && reg_tag == wtag)
      e = '{data: wdata, tag: TAG_INVALID};
    else
      e = '{data: reg_data, tag: reg_tag};
    return e;
  endfunction

  always_comb begin
    state_d        = ST_IDLE;
    alloc_tag_d    = TAG_INVALID;
    rob_alloc_rd_d = rob_alloc_rd_q;
    rob_alloc_op_d = rob_alloc_op_q;
    unique case (state_q)
      ST_IDLE:  state_d = accept ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_d = accept ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) begin
      alloc_tag_d    = rob_idx_to_tag(bus.rob_avail_tag);
      rob_alloc_rd_d = bus.alloc_rd;
      rob_alloc_op_d = bus.alloc_op;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (bus.flush)
      inflight_d = '0;
    else if (accept && !retire)
      inflight_d = inflight_q + 1'b1;
    else if (retire && !accept)
      inflight_d = inflight_q - 1'b1;
  end

  // Retiring data always lands, even on a flush edge or while a younger rename is pending.
  always_comb begin
    data_d = data_q;
    if (wb_valid && bus.wb_rd != '0) data_d[bus.wb_rd] = bus.wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      alloc_tag_q    <= TAG_INVALID;
      rob_alloc_rd_q <= '0;
      rob_alloc_op_q <= '0;
      inflight_q     <= '0;
      for (int i = 0; i < REG_NUM; i++) data_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      alloc_tag_q    <= alloc_tag_d;
      rob_alloc_rd_q <= rob_alloc_rd_d;
      rob_alloc_op_q <= rob_alloc_op_d;
      inflight_q     <= inflight_d;
      data_q         <= data_d;
    end
  end

  rename_tag_table u_tag_table (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .alloc_en  (accept),
    .alloc_rd  (bus.alloc_rd),
    .alloc_tag (rob_idx_to_tag(bus.rob_avail_tag)),
    .wb_en     (wb_valid),
    .wb_rd     (bus.wb_rd),
    .wb_tag    (bus.wb_tag),
    .rs1_addr  (bus.rs1_addr),
    .rs2_addr  (bus.rs2_addr),
    .rs1_tag   (rs1_tag_raw),
    .rs2_tag   (rs2_tag_raw)
  );

  always_comb begin
    rs1_ent = read_port(bus.rs1_addr, data_q[bus.rs1_addr], rs1_tag_raw,
                        wb_valid, bus.wb_rd, bus.wb_tag, bus.wb_data);
    rs2_ent = read_port(bus.rs2_addr, data_q[bus.rs2_addr], rs2_tag_raw,
                        wb_valid, bus.wb_rd, bus.wb_tag, bus.wb_data);
  end

  assign bus.rs1_data        = rs1_ent.data;
  assign bus.rs1_tag         = rs1_ent.tag;
  assign bus.rs2_data        = rs2_ent.data;
  assign bus.rs2_tag         = rs2_ent.tag;
  assign bus.alloc_ack       = (state_q == ST_GRANT);
  assign bus.rob_alloc_valid = (state_q == ST_GRANT);
  assign bus.alloc_tag       = alloc_tag_q;
  assign bus.rob_alloc_rd    = rob_alloc_rd_q;
  assign bus.rob_alloc_op    = rob_alloc_op_q;
  assign bus.inflight        = inflight_q;
endmodule
